// File: rtl/osc_power_sequencer.sv
// Oscillator power sequencer: collects client requests, powers the oscillator,
// waits out its startup time, grants requesters, then powers down after an
// idle hold-off and enforces a minimum off time before the next power-up.
// Optional build macro OSC_STATS_EN adds a saturating power-up counter output.
module osc_power_sequencer #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned STARTUP_CYCLES = 100,
  parameter int unsigned HOLDOFF_CYCLES = 16,
  parameter int unsigned MIN_OFF_CYCLES = 8,
  parameter int unsigned CNT_W          = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               power,
  output logic               osc_ready,
  output logic               busy,
  output logic [2:0]         state
`ifdef OSC_STATS_EN
  ,
  output logic [15:0]        powerup_count
`endif
);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_STARTUP  = 3'd1,
    ST_READY    = 3'd2,
    ST_HOLDOFF  = 3'd3,
    ST_COOLDOWN = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] STARTUP_LD = CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLDOFF_LD = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_OFF_LD = CNT_W'(MIN_OFF_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_dec;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               power_q, power_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               any_req;

  assign any_req = |req;
  // Down-counter saturates at zero instead of wrapping.
  assign cnt_dec = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_dec;
    grant_d = '0;
    power_d = power_q;
    ready_d = ready_q;
    unique case (state_q)
      ST_OFF: begin
        if (any_req && cnt_q == '0) begin
          state_d = ST_STARTUP;
          cnt_d   = STARTUP_LD;
          power_d = 1'b1;
        end
      end
      ST_STARTUP: begin
        if (cnt_q == '0) begin
          state_d = ST_READY;
          ready_d = 1'b1;
          grant_d = req;
        end
      end
      ST_READY: begin
        if (!any_req) begin
          state_d = ST_HOLDOFF;
          cnt_d   = HOLDOFF_LD;
        end else begin
          grant_d = req;
        end
      end
      ST_HOLDOFF: begin
        if (any_req) begin
          state_d = ST_READY;
          grant_d = req;
        end else if (cnt_q == '0) begin
          state_d = ST_COOLDOWN;
          cnt_d   = MIN_OFF_LD;
          power_d = 1'b0;
          ready_d = 1'b0;
        end
      end
      ST_COOLDOWN: begin
        if (cnt_q == '0) begin
          state_d = ST_OFF;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
        power_d = 1'b0;
        ready_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_OFF);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      grant_q <= '0;
      power_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      power_q <= power_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign grant     = grant_q;
  assign power     = power_q;
  assign osc_ready = ready_q;
  assign busy      = busy_q;
  assign state     = state_q;

`ifdef OSC_STATS_EN
  logic [15:0] powerup_q, powerup_d;

  // Count OFF->STARTUP transitions, saturating at all-ones.
  always_comb begin
    powerup_d = powerup_q;
    if (state_q == ST_OFF && state_d == ST_STARTUP && powerup_q != '1) begin
      powerup_d = powerup_q + 16'd1;
    end
  end

  // Power-up counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      powerup_q <= '0;
    end else begin
      powerup_q <= powerup_d;
    end
  end

  assign powerup_count = powerup_q;
`endif

endmodule

// File: tb/tb_osc_power_sequencer.sv
// Self-checking bench for osc_power_sequencer (default parameters).
module tb_osc_power_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] grant;
  logic       power;
  logic       osc_ready;
  logic       busy;
  logic [2:0] state;
`ifdef OSC_STATS_EN
  logic [15:0] powerup_count;
`endif

  osc_power_sequencer #(
    .NUM_REQ       (4),
    .STARTUP_CYCLES(100),
    .HOLDOFF_CYCLES(16),
    .MIN_OFF_CYCLES(8),
    .CNT_W         (16)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .grant    (grant),
    .power    (power),
    .osc_ready(osc_ready),
    .busy     (busy),
    .state    (state)
`ifdef OSC_STATS_EN
    ,
    .powerup_count(powerup_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  req;
    int unsigned reps;
    logic [3:0]  grant;
    logic        power;
    logic        ready;
    logic [2:0]  st;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] grant;
    logic       power;
    logic       ready;
    logic       busy;
    logic [2:0] st;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input string n, input logic r, input logic [3:0] rq,
                     input int unsigned reps, input logic [3:0] g,
                     input logic p, input logic rd, input logic [2:0] s);
    vec_t v;
    v.name = n; v.rst = r; v.req = rq; v.reps = reps;
    v.grant = g; v.power = p; v.ready = rd; v.st = s;
    vecs.push_back(v);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: empty queue at sample time %0t", $time);
    end else begin
      e = sb.pop_front();
      checks++;
      if ({grant, power, osc_ready, busy, state} !==
          {e.grant, e.power, e.ready, e.busy, e.st}) begin
        errors++;
        $display("FAIL %s @%0t: got grant=%b power=%b ready=%b busy=%b state=%0d, expected grant=%b power=%b ready=%b busy=%b state=%0d",
                 e.name, $time, grant, power, osc_ready, busy, state,
                 e.grant, e.power, e.ready, e.busy, e.st);
      end
    end
  endtask

  // Drive one cycle of stimulus, queue its expected outputs, sample after the edge.
  task automatic step(input string n, input logic r, input logic [3:0] rq,
                      input logic [3:0] g, input logic p, input logic rd,
                      input logic [2:0] s);
    exp_t e;
    reset = r;
    req   = rq;
    e.name = n; e.grant = g; e.power = p; e.ready = rd;
    e.busy = (s != 3'd0); e.st = s;
    sb.push_back(e);
    @(posedge clock);
    #1;
    check_out();
  endtask

  task automatic run_table();
    foreach (vecs[i]) begin
      for (int unsigned k = 0; k < vecs[i].reps; k++) begin
        step(vecs[i].name, vecs[i].rst, vecs[i].req, vecs[i].grant,
             vecs[i].power, vecs[i].ready, vecs[i].st);
      end
    end
    vecs.delete();
  endtask

`ifdef OSC_STATS_EN
  task automatic chk_cnt(input string n, input logic [15:0] exp_v);
    checks++;
    if (powerup_count !== exp_v) begin
      errors++;
      $display("FAIL %s: got powerup_count=%h, expected %h", n, powerup_count, exp_v);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    req   = 4'b0000;

    // Reset state, including a request that must be ignored while in reset.
    step("reset0", 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0);
    step("reset1", 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 3'd0);

    //   name             rst   req      reps grant    pwr  rdy  state
    add("pwr_up",         1'b0, 4'b0001, 1,  4'b0000, 1'b1, 1'b0, 3'd1);
    add("startup",        1'b0, 4'b0001, 99, 4'b0000, 1'b1, 1'b0, 3'd1);
    add("ready_rise",     1'b0, 4'b0001, 1,  4'b0001, 1'b1, 1'b1, 3'd2);
    add("grant_0011",     1'b0, 4'b0011, 1,  4'b0011, 1'b1, 1'b1, 3'd2);
    add("grant_0010",     1'b0, 4'b0010, 1,  4'b0010, 1'b1, 1'b1, 3'd2);
    add("idle_enter",     1'b0, 4'b0000, 1,  4'b0000, 1'b1, 1'b1, 3'd3);
    add("idle_short",     1'b0, 4'b0000, 9,  4'b0000, 1'b1, 1'b1, 3'd3);
    add("rereq",          1'b0, 4'b0100, 1,  4'b0100, 1'b1, 1'b1, 3'd2);
    add("rereq_hold",     1'b0, 4'b0100, 1,  4'b0100, 1'b1, 1'b1, 3'd2);
    add("idle1",          1'b0, 4'b0000, 1,  4'b0000, 1'b1, 1'b1, 3'd3);
    add("idle2_16",       1'b0, 4'b0000, 15, 4'b0000, 1'b1, 1'b1, 3'd3);
    add("pwr_down_17",    1'b0, 4'b0000, 1,  4'b0000, 1'b0, 1'b0, 3'd4);
    add("cool_idle",      1'b0, 4'b0000, 1,  4'b0000, 1'b0, 1'b0, 3'd4);
    add("cool_req_wait",  1'b0, 4'b1000, 6,  4'b0000, 1'b0, 1'b0, 3'd4);
    add("cool_to_off",    1'b0, 4'b1000, 1,  4'b0000, 1'b0, 1'b0, 3'd0);
    add("pwr_up2",        1'b0, 4'b1000, 1,  4'b0000, 1'b1, 1'b0, 3'd1);
    add("startup2",       1'b0, 4'b1000, 99, 4'b0000, 1'b1, 1'b0, 3'd1);
    add("ready2",         1'b0, 4'b1000, 1,  4'b1000, 1'b1, 1'b1, 3'd2);
    add("ready2_multi",   1'b0, 4'b1111, 1,  4'b1111, 1'b1, 1'b1, 3'd2);
    run_table();

`ifdef OSC_STATS_EN
    chk_cnt("stats_two", 16'd2);
`endif

    // Reset while granted drops everything on the next edge; restart is immediate.
    step("rst_mid", 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 3'd0);
`ifdef OSC_STATS_EN
    chk_cnt("stats_reset", 16'd0);
`endif
    step("rst_release", 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b0, 3'd1);
`ifdef OSC_STATS_EN
    chk_cnt("stats_one", 16'd1);
`endif

    // Request dropped mid-startup: startup completes, then READY sees idle.
    add("startup3",       1'b0, 4'b1000, 50, 4'b0000, 1'b1, 1'b0, 3'd1);
    add("startup3_noreq", 1'b0, 4'b0000, 49, 4'b0000, 1'b1, 1'b0, 3'd1);
    add("ready3_idle",    1'b0, 4'b0000, 1,  4'b0000, 1'b1, 1'b1, 3'd2);
    add("hold3",          1'b0, 4'b0000, 16, 4'b0000, 1'b1, 1'b1, 3'd3);
    add("cool3",          1'b0, 4'b0000, 8,  4'b0000, 1'b0, 1'b0, 3'd4);
    add("off3",           1'b0, 4'b0000, 3,  4'b0000, 1'b0, 1'b0, 3'd0);
    run_table();

`ifdef OSC_STATS_EN
    force dut.powerup_q = 16'hFFFF;
    #1;
    release dut.powerup_q;
`endif
    step("pwr_up4", 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0, 3'd1);
`ifdef OSC_STATS_EN
    chk_cnt("stats_saturate", 16'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
